thresholding_cfg_loader: RTL and testbench

Configuration sequencer for the `thresholding` core's `cfg_*` port. It streams a full threshold table (C channels × 2^N−1 thresholds) into the core in channel-major order, generating the packed core address. It also serves random-access readback requests, matching each reply to its issued request and flagging spurious replies. It sits between the host/DMA threshold stream and the core; the core's stream datapath is untouched.

---
 rtl/thresholding_cfg_pkg.sv | 35 +++
 rtl/thresholding_cfg_addr_cnt.sv | 54 +++++
 rtl/thresholding_cfg_loader.sv | 169 ++++++++++++++++
 tb/tb_thresholding_cfg_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thresholding_cfg_pkg.sv
// Shared types and address helpers for the thresholding core configuration path.
// Latency: none, holds only types and pure functions.
// Backpressure: not applicable.
//
// Contents:
//   cfg_state_e     loader FSM state encoding
//   cfg_addr_width  width of the packed core config address
//   pack_cfg_addr   channel/threshold -> packed core address
package thresholding_cfg_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } cfg_state_e;

  // Address is {cf, pe, t}; a field whose range has a single value gets zero bits.
  function automatic int cfg_addr_width(input int n, input int c, input int pe);
    return n + $clog2(pe) + $clog2(c / pe);
  endfunction

  // t in the low N bits, then the PE lane (c % pe), then the fold (c / pe).
  // When pe == 1 the lane term is always zero and the fold lands directly
  // above t; when c == pe the fold term is always zero.
  function automatic int unsigned pack_cfg_addr(input int unsigned n,
                                                input int unsigned pe,
                                                input int unsigned c,
                                                input int unsigned t);
    int unsigned a;
    a = t;
    a = a | ((c % pe) << n);
    a = a | ((c / pe) << (n + $clog2(pe)));
    return a;
  endfunction

endpackage

// File: rtl/thresholding_cfg_addr_cnt.sv
// Nested t/pe/cf wrap counter walking the threshold table in channel-major order.
// Latency: count visible the cycle after inc; last is combinational from the count.
// Backpressure: none, advances only when inc is high.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        restart the walk at t=0, pe=0, cf=0
//   inc        advance one table entry
//   t, pe, cf  current threshold index, PE lane, fold
//   last       current entry is the final one of the table
module thresholding_cfg_addr_cnt #(
  parameter int N  = 4,
  parameter int PE = 2,
  parameter int CF = 3,
  parameter int PW = (PE > 1) ? $clog2(PE) : 1,
  parameter int FW = (CF > 1) ? $clog2(CF) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [N-1:0]  t,
  output logic [PW-1:0] pe,
  output logic [FW-1:0] cf,
  output logic          last
);

  localparam logic [N-1:0]  T_MAX  = N'((1 << N) - 2);
  localparam logic [PW-1:0] PE_MAX = PW'(PE - 1);
  localparam logic [FW-1:0] CF_MAX = FW'(CF - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      t  <= '0;
      pe <= '0;
      cf <= '0;
    end else if (inc) begin
      if (t == T_MAX) begin
        t <= '0;
        if (pe == PE_MAX) begin
          pe <= '0;
          cf <= (cf == CF_MAX) ? '0 : cf + FW'(1);
        end else begin
          pe <= pe + PW'(1);
        end
      end else begin
        t <= t + N'(1);
      end
    end
  end

  assign last = (t == T_MAX) && (pe == PE_MAX) && (cf == CF_MAX);

endmodule

// File: rtl/thresholding_cfg_loader.sv
// Config sequencer: streams a full threshold table into the core and serves readbacks.
// Latency: cfg_* registered, one cycle after the accepting handshake; replies pass through combinationally.
// Backpressure: irdy high for the whole load; rd_rdy drops at RB_DEPTH outstanding; replies cannot be stalled.
//
// Ports:
//   start_vld/start_rdy  full-table load request (only when idle with no reads in flight)
//   done                 pulse together with the final table write
//   ivld/irdy/idat       threshold word stream
//   rd_vld/rd_rdy        readback request, rd_cnl channel, rd_idx threshold index
//   rd_ovld/rd_q         readback reply (copy of cfg_rack/cfg_q)
//   err                  sticky: a reply arrived with nothing outstanding
//   cfg_en/cfg_we/cfg_a/cfg_d  core config port; cfg_rack/cfg_q core reply
module thresholding_cfg_loader
  import thresholding_cfg_pkg::*;
#(
  parameter int K        = 10,
  parameter int N        = 4,
  parameter int C        = 6,
  parameter int PE       = 2,
  parameter int RB_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_vld,
  output logic                                 start_rdy,
  output logic                                 done,
  input  logic                                 ivld,
  output logic                                 irdy,
  input  logic [K-1:0]                         idat,
  input  logic                                 rd_vld,
  output logic                                 rd_rdy,
  input  logic [$clog2(C)-1:0]                 rd_cnl,
  input  logic [N-1:0]                         rd_idx,
  output logic                                 rd_ovld,
  output logic [K-1:0]                         rd_q,
  output logic                                 err,
  output logic                                 cfg_en,
  output logic                                 cfg_we,
  output logic [cfg_addr_width(N, C, PE)-1:0]  cfg_a,
  output logic [K-1:0]                         cfg_d,
  input  logic                                 cfg_rack,
  input  logic [K-1:0]                         cfg_q
);

  localparam int CF = C / PE;
  localparam int PB = $clog2(PE);
  localparam int AW = cfg_addr_width(N, C, PE);
  localparam int PW = (PE > 1) ? $clog2(PE) : 1;
  localparam int FW = (CF > 1) ? $clog2(CF) : 1;
  localparam int OW = $clog2(RB_DEPTH + 1);

  if (C % PE != 0) begin : g_cfg_check
    $error("thresholding_cfg_loader: C must be a multiple of PE");
  end

  cfg_state_e     state_q, state_d;
  logic [OW-1:0]  outst_q;
  logic           start_acc, word_acc, rd_acc, rack_ok;
  logic [N-1:0]   cnt_t;
  logic [PW-1:0]  cnt_pe;
  logic [FW-1:0]  cnt_cf;
  logic           cnt_last;
  logic [AW-1:0]  wr_addr, rd_addr;

  thresholding_cfg_addr_cnt #(
    .N  (N),
    .PE (PE),
    .CF (CF),
    .PW (PW),
    .FW (FW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .inc  (word_acc),
    .t    (cnt_t),
    .pe   (cnt_pe),
    .cf   (cnt_cf),
    .last (cnt_last)
  );

  // The counter already holds the table position split into fields, so the
  // write address is a plain field placement; single-value fields are skipped.
  always_comb begin
    wr_addr          = '0;
    wr_addr[N-1:0]   = cnt_t;
    if (PE > 1) wr_addr = wr_addr | (AW'(cnt_pe) << N);
    if (CF > 1) wr_addr = wr_addr | (AW'(cnt_cf) << (N + PB));
  end

  // Readback index is not range-checked: rd_idx = 2^N-1 goes to the core as is.
  assign rd_addr = AW'(pack_cfg_addr(N, PE, 32'(rd_cnl), 32'(rd_idx)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake readies. Ready outputs are held low while rst is
  // asserted so nothing is accepted in a reset cycle. A pending start blocks
  // reads so the load wins a same-cycle tie.
  always_comb begin
    state_d   = state_q;
    irdy      = 1'b0;
    start_rdy = 1'b0;
    rd_rdy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_rdy = !rst && (outst_q == '0);
        rd_rdy    = !rst && (outst_q < OW'(RB_DEPTH)) && !start_vld;
        if (start_vld && start_rdy) state_d = S_LOAD;
      end
      S_LOAD: begin
        irdy = !rst;
        if (ivld && irdy && cnt_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign start_acc = start_vld && start_rdy;
  assign word_acc  = ivld && irdy;
  assign rd_acc    = rd_vld && rd_rdy;

  // Core port: one strobe per accepted item. Writes and reads are mutually
  // exclusive by state, so at most one of word_acc/rd_acc is ever set.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_en <= 1'b0;
      cfg_we <= 1'b0;
      cfg_a  <= '0;
      cfg_d  <= '0;
      done   <= 1'b0;
    end else begin
      cfg_en <= word_acc || rd_acc;
      cfg_we <= word_acc;
      done   <= word_acc && cnt_last;
      if (word_acc) begin
        cfg_a <= wr_addr;
        cfg_d <= idat;
      end else if (rd_acc) begin
        cfg_a <= rd_addr;
      end
    end
  end

  // Outstanding readbacks. A reply with nothing in flight is flagged and does
  // not move the counter; it is never matched against a same-cycle request.
  assign rack_ok = cfg_rack && (outst_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q <= '0;
      err     <= 1'b0;
    end else begin
      if (cfg_rack && (outst_q == '0)) err <= 1'b1;
      case ({rd_acc, rack_ok})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   outst_q <= outst_q - OW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  assign rd_ovld = cfg_rack;
  assign rd_q    = cfg_q;

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Self-checking bench for thresholding_cfg_loader (K=10, N=4, C=6, PE=2, RB_DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The bench plays the core: it stores observed writes and answers reads from that store.
module tb_thresholding_cfg_loader;

  localparam int K = 10, N = 4, C = 6, PE = 2, RB = 4;
  localparam int TPC = (1 << N) - 1;
  localparam int WORDS = C * TPC;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst, start_vld, start_rdy, done, ivld, irdy, rd_vld, rd_rdy, rd_ovld, err;
  logic cfg_en, cfg_we, cfg_rack;
  logic [K-1:0] idat, rd_q, cfg_d, cfg_q;
  logic [2:0] rd_cnl;
  logic [N-1:0] rd_idx;
  logic [AW-1:0] cfg_a;

  thresholding_cfg_loader #(.K(K), .N(N), .C(C), .PE(PE), .RB_DEPTH(RB)) dut (
    .clk(clk), .rst(rst), .start_vld(start_vld), .start_rdy(start_rdy), .done(done),
    .ivld(ivld), .irdy(irdy), .idat(idat), .rd_vld(rd_vld), .rd_rdy(rd_rdy),
    .rd_cnl(rd_cnl), .rd_idx(rd_idx), .rd_ovld(rd_ovld), .rd_q(rd_q), .err(err),
    .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_a(cfg_a), .cfg_d(cfg_d),
    .cfg_rack(cfg_rack), .cfg_q(cfg_q)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model and write/read monitor
  logic [K-1:0] mem [0:(1<<AW)-1];
  int wr_a[$], wr_d[$], wr_c[$], done_c[$], rd_a[$];
  always @(negedge clk) begin
    if (cfg_en && cfg_we) begin
      wr_a.push_back(int'(cfg_a));
      wr_d.push_back(int'(cfg_d));
      wr_c.push_back(cyc);
      mem[cfg_a] = cfg_d;
    end
    if (cfg_en && !cfg_we) rd_a.push_back(int'(cfg_a));
    if (done) done_c.push_back(cyc);
  end

  // Reference: table contents as sent, and address arithmetic from the packing rule
  logic [K-1:0] ref_tbl [C][TPC];

  function automatic int exp_addr(input int c, input int t);
    return t + (c % PE) * (1 << N) + (c / PE) * (1 << N) * PE;
  endfunction

  typedef struct { int cnl; int idx; int addr; } rd_vec_t;
  rd_vec_t vec [8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: full rate, 1: valid every third cycle, 2: random gaps
  task automatic run_load(input int mode, input int nwords, input bit chk_tie);
    int k, budget;
    logic acc;
    wr_a.delete(); wr_d.delete(); wr_c.delete(); done_c.delete();
    start_vld = 1'b1;
    budget = 0;
    @(negedge clk);
    while (!start_rdy && budget < 100) begin
      tick();
      @(negedge clk);
      budget++;
    end
    check("start_rdy_wait", start_rdy, 1);
    if (chk_tie) check("tie_rd_rdy_low", rd_rdy, 0);
    tick();
    start_vld = 1'b0;
    k = 0;
    budget = 0;
    while (k < nwords && budget < 2000) begin
      case (mode)
        0:       ivld = 1'b1;
        1:       ivld = (budget % 3 == 0);
        default: ivld = ($urandom_range(0, 2) != 0);
      endcase
      idat = K'($urandom);
      @(negedge clk);
      acc = ivld && irdy;
      @(posedge clk);
      if (acc) begin
        ref_tbl[k / TPC][k % TPC] = idat;
        k++;
      end
      #1;
      budget++;
    end
    ivld = 1'b0;
    check("load_words_accepted", k, nwords);
  endtask

  task automatic verify_seq(input string tag, input bit full_rate);
    int bad_a, bad_d;
    bad_a = 0;
    bad_d = 0;
    check({tag, "_nwrites"}, wr_a.size(), WORDS);
    for (int k = 0; k < wr_a.size() && k < WORDS; k++) begin
      if (wr_a[k] != exp_addr(k / TPC, k % TPC)) bad_a++;
      if (wr_d[k] != int'(ref_tbl[k / TPC][k % TPC])) bad_d++;
    end
    check({tag, "_addr_bad"}, bad_a, 0);
    check({tag, "_data_bad"}, bad_d, 0);
    check({tag, "_ndone"}, done_c.size(), 1);
    if (wr_a.size() == WORDS) begin
      check({tag, "_word0_addr"}, wr_a[0], 0);
      check({tag, "_word15_addr"}, wr_a[15], 16);
      if (done_c.size() == 1) check({tag, "_done_cycle"}, done_c[0], wr_c[WORDS-1]);
      if (full_rate) check({tag, "_span"}, wr_c[WORDS-1] - wr_c[0], WORDS - 1);
    end
  endtask

  task automatic issue_read(input int c, input int t, input int ea);
    int budget;
    budget = 0;
    rd_cnl = 3'(c);
    rd_idx = N'(t);
    rd_vld = 1'b1;
    @(negedge clk);
    while (!rd_rdy && budget < 200) begin
      tick();
      @(negedge clk);
      budget++;
    end
    check("rd_rdy_wait", rd_rdy, 1);
    tick();
    rd_vld = 1'b0;
    @(negedge clk);
    check("rd_cfg_en", cfg_en, 1);
    check("rd_cfg_we", cfg_we, 0);
    check("rd_cfg_a", cfg_a, ea);
    tick();
  endtask

  task automatic reply(input string name, input bit chk_data, input int exp_d);
    int a;
    check({name, "_pending"}, rd_a.size() > 0, 1);
    if (rd_a.size() == 0) return;
    a = rd_a.pop_front();
    cfg_rack = 1'b1;
    cfg_q = mem[a];
    @(negedge clk);
    check({name, "_ovld"}, rd_ovld, 1);
    if (chk_data) check({name, "_q"}, rd_q, exp_d);
    tick();
    cfg_rack = 1'b0;
  endtask

  initial begin
    int nrd, outst, a, c, t;
    int exp_a_q[$], exp_d_q[$];
    vec[0] = '{0, 0, 0};   vec[1] = '{1, 0, 16};  vec[2] = '{2, 7, 39};
    vec[3] = '{5, 14, 94}; vec[4] = '{3, 7, 55};  vec[5] = '{4, 15, 79};
    vec[6] = '{4, 3, 67};  vec[7] = '{1, 14, 30};

    rst = 1'b1; start_vld = 0; ivld = 0; idat = '0; rd_vld = 0; rd_cnl = '0; rd_idx = '0;
    cfg_rack = 0; cfg_q = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_start_rdy", start_rdy, 0);
    check("rst_rd_rdy", rd_rdy, 0);
    check("rst_irdy", irdy, 0);
    check("rst_cfg_en", cfg_en, 0);
    check("rst_cfg_a", cfg_a, 0);
    check("rst_cfg_d", cfg_d, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_start_rdy", start_rdy, 1);
    check("idle_rd_rdy", rd_rdy, 1);
    tick();

    // Full-rate load
    run_load(0, WORDS, 1'b0);
    @(negedge clk);
    check("full_done_pulse", done, 1);
    check("full_last_we", cfg_we, 1);
    check("full_irdy_after", irdy, 0);
    tick();
    @(negedge clk);
    check("full_done_clear", done, 0);
    check("full_cfg_en_idle", cfg_en, 0);
    check("full_start_rdy_again", start_rdy, 1);
    tick();
    verify_seq("full", 1'b1);

    // Table readbacks: fill the outstanding window, then free one slot
    for (int i = 0; i < 4; i++) issue_read(vec[i].cnl, vec[i].idx, vec[i].addr);
    rd_cnl = 3'(vec[4].cnl); rd_idx = N'(vec[4].idx); rd_vld = 1'b1;
    @(negedge clk);
    check("window_full_rd_rdy", rd_rdy, 0);
    tick();
    @(negedge clk);
    check("window_full_no_issue", cfg_en, 0);
    tick();
    reply("vec0", 1'b1, int'(ref_tbl[vec[0].cnl][vec[0].idx]));
    @(negedge clk);
    check("slot_freed_rd_rdy", rd_rdy, 1);
    tick();
    rd_vld = 1'b0;
    @(negedge clk);
    check("vec4_cfg_a", cfg_a, vec[4].addr);
    tick();
    for (int i = 1; i < 5; i++)
      reply($sformatf("vec%0d", i), 1'b1, int'(ref_tbl[vec[i].cnl][vec[i].idx]));
    for (int i = 5; i < 8; i++) begin
      issue_read(vec[i].cnl, vec[i].idx, vec[i].addr);
      reply($sformatf("vec%0d", i), vec[i].idx < TPC,
            (vec[i].idx < TPC) ? int'(ref_tbl[vec[i].cnl][vec[i].idx % TPC]) : 0);
    end

    // start and read offered together: start wins, read waits for the load
    rd_cnl = 3'(5); rd_idx = N'(14); rd_vld = 1'b1;
    nrd = rd_a.size();
    run_load(2, WORDS, 1'b1);
    @(negedge clk);
    check("tie_done_pulse", done, 1);
    check("tie_no_read_during_load", rd_a.size(), nrd);
    tick();
    @(negedge clk);
    rd_vld = 1'b0;
    check("tie_read_after_done", cfg_en && !cfg_we, 1);
    check("tie_read_addr", cfg_a, 94);
    tick();
    verify_seq("tie", 1'b0);
    reply("tie_reply", 1'b1, int'(ref_tbl[5][14]));

    // Throttled load, one valid in three cycles
    run_load(1, WORDS, 1'b0);
    @(negedge clk);
    check("thr_done_pulse", done, 1);
    tick();
    tick();
    verify_seq("thr", 1'b0);

    // Random readbacks against an in-order request queue
    outst = 0;
    for (int i = 0; i < 80; i++) begin
      if (outst > 0 && $urandom_range(0, 2) == 0) begin
        check("rnd_pending", rd_a.size() > 0, 1);
        if (rd_a.size() > 0) begin
          a = rd_a.pop_front();
          cfg_rack = 1'b1;
          cfg_q = mem[a];
          @(negedge clk);
          check("rnd_reply_addr", a, exp_a_q.pop_front());
          check("rnd_reply_q", rd_q, exp_d_q.pop_front());
          tick();
          cfg_rack = 1'b0;
        end
        outst--;
      end else begin
        c = $urandom_range(0, C - 1);
        t = $urandom_range(0, TPC - 1);
        rd_cnl = 3'(c); rd_idx = N'(t); rd_vld = 1'b1;
        @(negedge clk);
        check("rnd_rd_rdy", rd_rdy, outst < RB);
        tick();
        rd_vld = 1'b0;
        if (outst < RB) begin
          exp_a_q.push_back(exp_addr(c, t));
          exp_d_q.push_back(int'(ref_tbl[c][t]));
          outst++;
        end
        tick();
      end
    end
    while (outst > 0) begin
      reply("rnd_drain", 1'b1, exp_d_q.pop_front());
      outst--;
    end

    // Spurious reply: sticky err, counter stays at zero
    cfg_rack = 1'b1; cfg_q = '0;
    @(negedge clk);
    check("spur_err_before", err, 0);
    tick();
    cfg_rack = 1'b0;
    @(negedge clk);
    check("spur_err_set", err, 1);
    repeat (5) tick();
    @(negedge clk);
    check("spur_err_sticky", err, 1);
    check("spur_start_rdy", start_rdy, 1);
    tick();

    // Reset after word 40 of a load
    run_load(0, 41, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_irdy", irdy, 0);
    check("mid_rst_start_rdy", start_rdy, 0);
    check("mid_rst_rd_rdy", rd_rdy, 0);
    tick();
    @(negedge clk);
    check("mid_rst_cfg_en", cfg_en, 0);
    check("mid_rst_cfg_a", cfg_a, 0);
    check("mid_rst_cfg_d", cfg_d, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_no_done", done_c.size(), 0);
    tick();
    rst = 1'b0;
    tick();
    run_load(0, WORDS, 1'b0);
    tick();
    tick();
    verify_seq("reload", 1'b1);

    // Reset with a read in flight: the late reply is spurious
    issue_read(vec[0].cnl, vec[0].idx, vec[0].addr);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg_rack = 1'b1;
    tick();
    cfg_rack = 1'b0;
    @(negedge clk);
    check("late_rack_err", err, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
